// File: rtl/ps2_note_keys.sv
// ps2_note_keys: PS/2 set-2 keyboard receiver that validates 11-bit frames
// and turns make/break codes for twelve keys into held-note enables.
module ps2_note_keys #(
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic        CLOCK_50,
    input  logic        reset,
    input  logic        PS2_CLK,
    input  logic        PS2_DAT,
    output logic [11:0] notes,
    output logic [7:0]  scancode,
    output logic        code_valid,
    output logic        frame_error
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_BRK,
        ST_EXT,
        ST_EXT_BRK
    } dec_state_t;

    logic          clk_meta_q, clk_sync_q, clk_prev_q;
    logic          dat_meta_q, dat_sync_q;
    logic [3:0]    bitcnt_q, bitcnt_d;
    logic [10:0]   shift_q, shift_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic [7:0]    scancode_q, scancode_d;
    logic          code_valid_q, code_valid_d;
    logic          frame_error_q, frame_error_d;
    logic [11:0]   notes_q;
    dec_state_t    state_q;

    logic          fall;
    logic [10:0]   word;
    logic          frame_done, frame_ok, tmo_abort, accept;
    logic [7:0]    byte_in;
    logic [11:0]   key_hot;

    // One-hot note bit for a mapped set-2 make code, zero for anything else.
    function automatic logic [11:0] key_onehot(input logic [7:0] code);
        case (code)
            8'h1C:   key_onehot = 12'h001;
            8'h1D:   key_onehot = 12'h002;
            8'h1B:   key_onehot = 12'h004;
            8'h24:   key_onehot = 12'h008;
            8'h23:   key_onehot = 12'h010;
            8'h2B:   key_onehot = 12'h020;
            8'h2C:   key_onehot = 12'h040;
            8'h34:   key_onehot = 12'h080;
            8'h35:   key_onehot = 12'h100;
            8'h33:   key_onehot = 12'h200;
            8'h3C:   key_onehot = 12'h400;
            8'h3B:   key_onehot = 12'h800;
            default: key_onehot = 12'h000;
        endcase
    endfunction

    // Two-flop synchronizers on both pins plus the previous-clock flop; idle bus is high.
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            clk_meta_q <= 1'b1;
            clk_sync_q <= 1'b1;
            clk_prev_q <= 1'b1;
            dat_meta_q <= 1'b1;
            dat_sync_q <= 1'b1;
        end else begin
            clk_meta_q <= PS2_CLK;
            clk_sync_q <= clk_meta_q;
            clk_prev_q <= clk_sync_q;
            dat_meta_q <= PS2_DAT;
            dat_sync_q <= dat_meta_q;
        end
    end

    assign fall    = clk_prev_q & ~clk_sync_q;
    // Bits enter at the top so after eleven edges word[0] is start and word[10] stop.
    assign word    = {dat_sync_q, shift_q[10:1]};
    assign byte_in = word[8:1];
    assign key_hot = key_onehot(byte_in);

    // Frame receiver: bit counting, shifting, inter-edge timeout and frame checks.
    always_comb begin
        bitcnt_d   = bitcnt_q;
        shift_d    = shift_q;
        tmo_d      = tmo_q;
        frame_done = 1'b0;
        tmo_abort  = 1'b0;
        if (fall) begin
            // An edge always beats a simultaneous timeout.
            shift_d = word;
            tmo_d   = '0;
            if (bitcnt_q == 4'd10) begin
                bitcnt_d   = 4'd0;
                frame_done = 1'b1;
            end else begin
                bitcnt_d = bitcnt_q + 4'd1;
            end
        end else if (bitcnt_q != 4'd0) begin
            if (tmo_q == TMO_LAST) begin
                bitcnt_d  = 4'd0;
                tmo_d     = '0;
                tmo_abort = 1'b1;
            end else begin
                tmo_d = tmo_q + 1'b1;
            end
        end else begin
            tmo_d = '0;
        end
        // Odd parity across the data byte and the parity bit.
        frame_ok      = ~word[0] & word[10] & (^word[9:1]);
        accept        = frame_done & frame_ok;
        code_valid_d  = accept;
        frame_error_d = (frame_done & ~frame_ok) | tmo_abort;
        scancode_d    = accept ? byte_in : scancode_q;
    end

    // Receiver and debug-output registers.
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            bitcnt_q      <= 4'd0;
            shift_q       <= '0;
            tmo_q         <= '0;
            scancode_q    <= 8'h00;
            code_valid_q  <= 1'b0;
            frame_error_q <= 1'b0;
        end else begin
            bitcnt_q      <= bitcnt_d;
            shift_q       <= shift_d;
            tmo_q         <= tmo_d;
            scancode_q    <= scancode_d;
            code_valid_q  <= code_valid_d;
            frame_error_q <= frame_error_d;
        end
    end

    // Make/break decoder, stepped only by accepted bytes so notes move with code_valid.
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            notes_q <= 12'h000;
        end else if (accept) begin
            case (state_q)
                ST_IDLE: begin
                    if (byte_in == 8'hF0)      state_q <= ST_BRK;
                    else if (byte_in == 8'hE0) state_q <= ST_EXT;
                    else if (byte_in == 8'h76) notes_q <= 12'h000;
                    else                       notes_q <= notes_q | key_hot;
                end
                ST_BRK: begin
                    notes_q <= notes_q & ~key_hot;
                    state_q <= ST_IDLE;
                end
                ST_EXT:     state_q <= (byte_in == 8'hF0) ? ST_EXT_BRK : ST_IDLE;
                ST_EXT_BRK: state_q <= ST_IDLE;
                default:    state_q <= ST_IDLE;
            endcase
        end
    end

    assign notes       = notes_q;
    assign scancode    = scancode_q;
    assign code_valid  = code_valid_q;
    assign frame_error = frame_error_q;

endmodule

// File: tb/tb_ps2_note_keys.sv
// Bench for ps2_note_keys: directed scenarios plus random frames checked
// against a key-event model of held notes.
module tb_ps2_note_keys;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic ps_clk = 1'b1, ps_dat = 1'b1;
    logic sel = 1'b0;  // 0: traffic to dut_a, 1: traffic to dut_b (short timeout)

    logic        a_clk, a_dat, b_clk, b_dat;
    logic [11:0] notes_a, notes_b;
    logic [7:0]  scan_a, scan_b;
    logic        cv_a, fe_a, cv_b, fe_b;

    assign a_clk = sel ? 1'b1 : ps_clk;
    assign a_dat = sel ? 1'b1 : ps_dat;
    assign b_clk = sel ? ps_clk : 1'b1;
    assign b_dat = sel ? ps_dat : 1'b1;

    ps2_note_keys dut_a (
        .CLOCK_50(clk), .reset(rst), .PS2_CLK(a_clk), .PS2_DAT(a_dat),
        .notes(notes_a), .scancode(scan_a), .code_valid(cv_a), .frame_error(fe_a)
    );

    ps2_note_keys #(.TIMEOUT_CYCLES(100)) dut_b (
        .CLOCK_50(clk), .reset(rst), .PS2_CLK(b_clk), .PS2_DAT(b_dat),
        .notes(notes_b), .scancode(scan_b), .code_valid(cv_b), .frame_error(fe_b)
    );

    always #10 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc = cyc + 1;

    int n_chk = 0, n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Pulse monitors, sampled on the falling clock edge.
    int cv_cnt = 0, fe_cnt = 0, cv_cyc = 0, fe_cyc = 0;
    int fe_b_cnt = 0, fe_b_cyc = 0;
    always @(negedge clk) begin
        if (cv_a) begin cv_cnt++; cv_cyc = cyc; end
        if (fe_a) begin fe_cnt++; fe_cyc = cyc; end
        if (fe_b) begin fe_b_cnt++; fe_b_cyc = cyc; end
        if (cv_a && fe_a) chk("cv_fe_excl", 32'd1, 32'd0);
    end

    // Reference model: held-note set driven by key events with prefix context.
    logic [7:0]  keys [12] = '{8'h1C, 8'h1D, 8'h1B, 8'h24, 8'h23, 8'h2B,
                               8'h2C, 8'h34, 8'h35, 8'h33, 8'h3C, 8'h3B};
    logic [11:0] m_notes = 12'h000;
    logic [7:0]  m_scan = 8'h00;
    bit          pend_brk = 0, pend_ext = 0;
    int          exp_cv = 0, exp_fe = 0, last_fall = 0;

    function automatic int key_idx(input logic [7:0] b);
        for (int i = 0; i < 12; i++) if (keys[i] == b) return i;
        return -1;
    endfunction

    task automatic model_byte(input logic [7:0] b);
        int k;
        k = key_idx(b);
        m_scan = b;
        if (pend_ext) begin
            // Extended sequences never affect notes; only E0 F0 needs one more byte.
            if (!pend_brk && b == 8'hF0) pend_brk = 1;
            else begin pend_ext = 0; pend_brk = 0; end
        end else if (pend_brk) begin
            if (k >= 0) m_notes[k] = 1'b0;
            pend_brk = 0;
        end else if (b == 8'hF0) pend_brk = 1;
        else if (b == 8'hE0) pend_ext = 1;
        else if (b == 8'h76) m_notes = 12'h000;
        else if (k >= 0) m_notes[k] = 1'b1;
    endtask

    task automatic model_reset();
        m_notes = 12'h000; m_scan = 8'h00; pend_brk = 0; pend_ext = 0;
    endtask

    // Drive nbits of a frame (start, D0..D7, parity, stop); falls land on negedges.
    task automatic send_frame(input logic [7:0] b, input bit bad, input int half, input int nbits);
        logic [10:0] fr;
        fr = {1'b1, (~^b) ^ bad, b, 1'b0};
        for (int i = 0; i < nbits; i++) begin
            ps_dat = fr[i];
            repeat (half) @(negedge clk);
            last_fall = cyc;
            ps_clk = 1'b0;
            repeat (half) @(negedge clk);
            ps_clk = 1'b1;
        end
        ps_dat = 1'b1;
    endtask

    task automatic frame_a(input logic [7:0] b, input bit bad, input int half);
        send_frame(b, bad, half, 11);
        repeat (5) @(negedge clk);
        if (!bad) begin
            model_byte(b);
            exp_cv++;
            chk("cv_latency", cv_cyc - last_fall, 3);
        end else begin
            exp_fe++;
            chk("fe_latency", fe_cyc - last_fall, 3);
        end
        chk("cv_count", cv_cnt, exp_cv);
        chk("fe_count", fe_cnt, exp_fe);
        chk("scancode", {24'h0, scan_a}, {24'h0, m_scan});
        chk("notes", {20'h0, notes_a}, {20'h0, m_notes});
    endtask

    initial begin
        repeat (5) @(negedge clk);
        chk("rst_notes", {20'h0, notes_a}, 32'h0);
        chk("rst_scan", {24'h0, scan_a}, 32'h0);
        chk("rst_cv", {31'h0, cv_a}, 32'h0);
        chk("rst_fe", {31'h0, fe_a}, 32'h0);
        rst = 1'b0;
        repeat (5) @(negedge clk);

        // Single make/break; first frame at the slow 1000-cycle half period.
        frame_a(8'h1C, 0, 1000);
        chk("make_C", {20'h0, notes_a}, 32'h001);
        frame_a(8'hF0, 0, 30);
        frame_a(8'h1C, 0, 30);
        chk("break_C", {20'h0, notes_a}, 32'h000);

        // Chord then Esc.
        frame_a(8'h1C, 0, 30);
        frame_a(8'h23, 0, 30);
        frame_a(8'h34, 0, 30);
        chk("chord", {20'h0, notes_a}, 32'h091);
        frame_a(8'h76, 0, 30);
        chk("esc", {20'h0, notes_a}, 32'h000);

        // Bad parity then good S.
        frame_a(8'h1C, 1, 30);
        frame_a(8'h1B, 0, 30);
        chk("after_bad", {20'h0, notes_a}, 32'h004);
        frame_a(8'h76, 0, 30);

        // Extended make and break, then plain C.
        frame_a(8'hE0, 0, 30);
        frame_a(8'h1C, 0, 30);
        frame_a(8'hE0, 0, 30);
        frame_a(8'hF0, 0, 30);
        frame_a(8'h1C, 0, 30);
        chk("ext_none", {20'h0, notes_a}, 32'h000);
        frame_a(8'h1C, 0, 30);
        chk("ext_idle", {20'h0, notes_a}, 32'h001);

        // Reset mid-frame while C is held.
        send_frame(8'h1D, 0, 30, 6);
        rst = 1'b1;
        #1;
        chk("mid_rst_notes", {20'h0, notes_a}, 32'h0);
        chk("mid_rst_scan", {24'h0, scan_a}, 32'h0);
        chk("mid_rst_flags", {30'h0, cv_a, fe_a}, 32'h0);
        model_reset();
        repeat (5) @(negedge clk);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        frame_a(8'h1D, 0, 30);
        chk("post_rst", {20'h0, notes_a}, 32'h002);

        // Timeout on the short-timeout instance.
        sel = 1'b1;
        repeat (5) @(negedge clk);
        send_frame(8'h3B, 0, 25, 4);
        repeat (200) @(negedge clk);
        chk("tmo_count", fe_b_cnt, 1);
        chk("tmo_delay", (fe_b_cyc - last_fall >= 102 && fe_b_cyc - last_fall <= 103), 1);
        send_frame(8'h3B, 0, 25, 11);
        repeat (5) @(negedge clk);
        chk("tmo_recover", {20'h0, notes_b}, 32'h800);
        chk("tmo_scan", {24'h0, scan_b}, 32'h3B);
        sel = 1'b0;
        repeat (5) @(negedge clk);

        // Random traffic against the model.
        for (int n = 0; n < 40; n++) begin
            logic [7:0] b;
            int r;
            r = $urandom_range(0, 9);
            if (r < 5)       b = keys[$urandom_range(0, 11)];
            else if (r == 5) b = 8'hF0;
            else if (r == 6) b = 8'hE0;
            else if (r == 7) b = 8'h76;
            else             b = 8'($urandom);
            frame_a(b, ($urandom_range(0, 9) == 0), 30);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
